wb_stage: RTL and testbench



---
 rtl/wb_stage_if.sv | 41 ++++
 rtl/wb_stage.sv | 163 ++++++++++++++++
 tb/tb_wb_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Handshake and port bundle for the writeback stage: EXU issue, LSU read
// response, register-file write port, commit and hazard outputs.
interface wb_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            exu_valid;
  logic            exu_ready;
  logic [RA_W-1:0] exu_rd;
  logic            exu_rd_wen;
  logic [XLEN-1:0] exu_result;
  logic            exu_is_load;
  logic [2:0]      exu_funct3;
  logic [XLEN-1:0] exu_pc;
  logic            lsu_rvalid;
  logic            lsu_rready;
  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_rerr;
  logic            rf_wen;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [RA_W-1:0] wbu_rd;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            commit_err;
  logic [63:0]     instret;

  modport slave (
    input  exu_valid, exu_rd, exu_rd_wen, exu_result, exu_is_load, exu_funct3, exu_pc,
    input  lsu_rvalid, lsu_rdata, lsu_rerr,
    output exu_ready, lsu_rready, rf_wen, rf_waddr, rf_wdata, wbu_rd,
    output commit_valid, commit_pc, commit_err, instret
  );

  modport master (
    output exu_valid, exu_rd, exu_rd_wen, exu_result, exu_is_load, exu_funct3, exu_pc,
    output lsu_rvalid, lsu_rdata, lsu_rerr,
    input  exu_ready, lsu_rready, rf_wen, rf_waddr, rf_wdata, wbu_rd,
    input  commit_valid, commit_pc, commit_err, instret
  );
endinterface

// File: rtl/wb_stage.sv
// RV32E writeback stage: holds one instruction, waits for load data when
// needed, formats it, then writes the register file and retires in one cycle.
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int RA_W         = 5,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  wb_stage_if.slave  bus
);
  localparam int TMO_W = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [RA_W-1:0] rd_r, rd_nxt_s;
  logic            rd_wen_r, rd_wen_nxt_s;
  logic [XLEN-1:0] result_r, result_nxt_s;
  logic [2:0]      funct3_r, funct3_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s;
  logic            err_r, err_nxt_s;
  logic [TMO_W-1:0] tmo_r, tmo_nxt_s;

  logic            exu_ready_r, lsu_rready_r, rf_wen_r, commit_valid_r, commit_err_r;
  logic [RA_W-1:0] rf_waddr_r, wbu_rd_r;
  logic [XLEN-1:0] rf_wdata_r, commit_pc_r;
  logic [63:0]     instret_r;
  logic            write_nxt_s;

  // Lane select and extension of the raw aligned word for the load size.
  function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_fmt = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_fmt = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, h};
      default: load_fmt = word;
    endcase
  endfunction

  // Next-state and next held-field logic.
  always_comb begin
    state_nxt_s  = state_r;
    rd_nxt_s     = rd_r;
    rd_wen_nxt_s = rd_wen_r;
    result_nxt_s = result_r;
    funct3_nxt_s = funct3_r;
    pc_nxt_s     = pc_r;
    err_nxt_s    = err_r;
    tmo_nxt_s    = tmo_r;
    case (state_r)
      IDLE: begin
        tmo_nxt_s = {TMO_W{1'b0}};
        if (bus.exu_valid) begin
          rd_nxt_s     = bus.exu_rd;
          rd_wen_nxt_s = bus.exu_rd_wen;
          result_nxt_s = bus.exu_result;
          funct3_nxt_s = bus.exu_funct3;
          pc_nxt_s     = bus.exu_pc;
          err_nxt_s    = 1'b0;
          state_nxt_s  = bus.exu_is_load ? LOAD_WAIT : WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD_WAIT: begin
        tmo_nxt_s = tmo_r + TMO_W'(1);
        // A response in the limit cycle takes priority over the timeout.
        if (bus.lsu_rvalid) begin
          result_nxt_s = load_fmt(bus.lsu_rdata, funct3_r, result_r[1:0]);
          err_nxt_s    = bus.lsu_rerr;
          state_nxt_s  = WRITE;
        end else if (tmo_r == TMO_W'(LOAD_TIMEOUT - 1)) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = LOAD_WAIT;
        end
      end
      WRITE: begin
        tmo_nxt_s   = {TMO_W{1'b0}};
        state_nxt_s = IDLE;
      end
      default: begin
        tmo_nxt_s   = {TMO_W{1'b0}};
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign write_nxt_s = (state_nxt_s == WRITE);

  // State, held fields and registered outputs decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      rd_r           <= {RA_W{1'b0}};
      rd_wen_r       <= 1'b0;
      result_r       <= {XLEN{1'b0}};
      funct3_r       <= 3'b000;
      pc_r           <= {XLEN{1'b0}};
      err_r          <= 1'b0;
      tmo_r          <= {TMO_W{1'b0}};
      exu_ready_r    <= 1'b1;
      lsu_rready_r   <= 1'b0;
      rf_wen_r       <= 1'b0;
      rf_waddr_r     <= {RA_W{1'b0}};
      rf_wdata_r     <= {XLEN{1'b0}};
      wbu_rd_r       <= {RA_W{1'b0}};
      commit_valid_r <= 1'b0;
      commit_pc_r    <= {XLEN{1'b0}};
      commit_err_r   <= 1'b0;
      instret_r      <= 64'd0;
    end else begin
      state_r        <= state_nxt_s;
      rd_r           <= rd_nxt_s;
      rd_wen_r       <= rd_wen_nxt_s;
      result_r       <= result_nxt_s;
      funct3_r       <= funct3_nxt_s;
      pc_r           <= pc_nxt_s;
      err_r          <= err_nxt_s;
      tmo_r          <= tmo_nxt_s;
      exu_ready_r    <= (state_nxt_s == IDLE);
      lsu_rready_r   <= (state_nxt_s == LOAD_WAIT);
      rf_wen_r       <= write_nxt_s && rd_wen_nxt_s && (rd_nxt_s != {RA_W{1'b0}}) && !err_nxt_s;
      rf_waddr_r     <= rd_nxt_s;
      rf_wdata_r     <= result_nxt_s;
      wbu_rd_r       <= ((state_nxt_s != IDLE) && rd_wen_nxt_s) ? rd_nxt_s : {RA_W{1'b0}};
      commit_valid_r <= write_nxt_s;
      commit_pc_r    <= pc_nxt_s;
      commit_err_r   <= write_nxt_s && err_nxt_s;
      instret_r      <= (state_r == WRITE) ? instret_r + 64'd1 : instret_r;
    end
  end

  assign bus.exu_ready    = exu_ready_r;
  assign bus.lsu_rready   = lsu_rready_r;
  assign bus.rf_wen       = rf_wen_r;
  assign bus.rf_waddr     = rf_waddr_r;
  assign bus.rf_wdata     = rf_wdata_r;
  assign bus.wbu_rd       = wbu_rd_r;
  assign bus.commit_valid = commit_valid_r;
  assign bus.commit_pc    = commit_pc_r;
  assign bus.commit_err   = commit_err_r;
  assign bus.instret      = instret_r;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected retires are queued at issue and
// compared when commit_valid appears.
module tb_wb_stage;
  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   commits_seen;
  int   commits_exp;
  longint instret_exp;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;
  exp_t sb[$];

  wb_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  wb_stage #(.XLEN(32), .RA_W(5), .LOAD_TIMEOUT(255)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.commit_valid === 1'b1) commits_seen <= commits_seen + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wen, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] pc, input logic err);
    exp_t e;
    e.wen = wen; e.addr = a; e.data = d; e.pc = pc; e.err = err;
    sb.push_back(e);
    commits_exp++;
  endtask

  task automatic expect_commit(input string tag, input int bound, output int waited);
    exp_t e;
    bit seen;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < bound) begin
      if (bus.commit_valid === 1'b1) seen = 1'b1;
      else begin
        @(negedge clock);
        waited++;
      end
    end
    check({tag, "_seen"}, {63'd0, seen}, 64'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rf_wen"}, {63'd0, bus.rf_wen}, {63'd0, e.wen});
      check({tag, "_waddr"}, {59'd0, bus.rf_waddr}, {59'd0, e.addr});
      check({tag, "_wdata"}, {32'd0, bus.rf_wdata}, {32'd0, e.data});
      check({tag, "_pc"}, {32'd0, bus.commit_pc}, {32'd0, e.pc});
      check({tag, "_err"}, {63'd0, bus.commit_err}, {63'd0, e.err});
      instret_exp++;
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                       input logic ld, input logic [2:0] f3, input logic [31:0] pc);
    check("ready_idle", {63'd0, bus.exu_ready}, 64'd1);
    bus.exu_valid = 1'b1; bus.exu_rd = rd; bus.exu_rd_wen = wen;
    bus.exu_result = res; bus.exu_is_load = ld; bus.exu_funct3 = f3; bus.exu_pc = pc;
    @(negedge clock);
    bus.exu_valid = 1'b0;
    check("ready_busy", {63'd0, bus.exu_ready}, 64'd0);
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [2:0] f3, input int delay, input logic [31:0] rdata,
                         input logic rerr);
    int w;
    issue(rd, 1'b1, addr, 1'b1, f3, 32'h0000_0100 + addr);
    check({tag, "_rready"}, {63'd0, bus.lsu_rready}, 64'd1);
    check({tag, "_wbu_rd_wait"}, {59'd0, bus.wbu_rd}, {59'd0, rd});
    repeat (delay) @(negedge clock);
    bus.lsu_rvalid = 1'b1; bus.lsu_rdata = rdata; bus.lsu_rerr = rerr;
    @(negedge clock);
    bus.lsu_rvalid = 1'b0; bus.lsu_rerr = 1'b0;
    check({tag, "_wbu_rd_write"}, {59'd0, bus.wbu_rd}, {59'd0, rd});
    expect_commit(tag, 1, w);
    @(negedge clock);
    check({tag, "_wbu_rd_after"}, {59'd0, bus.wbu_rd}, 64'd0);
    check({tag, "_instret"}, bus.instret, instret_exp);
  endtask

  initial begin
    int w;
    checks = 0; failures = 0; commits_seen = 0; commits_exp = 0; instret_exp = 0;
    reset = 1'b1;
    bus.exu_valid = 1'b0; bus.exu_rd = 5'd0; bus.exu_rd_wen = 1'b0; bus.exu_result = 32'd0;
    bus.exu_is_load = 1'b0; bus.exu_funct3 = 3'b000; bus.exu_pc = 32'd0;
    bus.lsu_rvalid = 1'b0; bus.lsu_rdata = 32'd0; bus.lsu_rerr = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", {63'd0, bus.exu_ready}, 64'd1);
    check("rst_rready", {63'd0, bus.lsu_rready}, 64'd0);
    check("rst_rf_wen", {63'd0, bus.rf_wen}, 64'd0);
    check("rst_commit", {63'd0, bus.commit_valid}, 64'd0);
    check("rst_wbu_rd", {59'd0, bus.wbu_rd}, 64'd0);
    check("rst_instret", bus.instret, 64'd0);

    // ALU op: WRITE in the cycle after acceptance.
    push(1'b1, 5'd5, 32'h0000_1234, 32'h8000_0000, 1'b0);
    issue(5'd5, 1'b1, 32'h0000_1234, 1'b0, 3'b000, 32'h8000_0000);
    check("alu_wbu_rd", {59'd0, bus.wbu_rd}, 64'd5);
    expect_commit("alu", 1, w);
    @(negedge clock);
    check("alu_ready_back", {63'd0, bus.exu_ready}, 64'd1);
    check("alu_commit_low", {63'd0, bus.commit_valid}, 64'd0);
    check("alu_instret", bus.instret, 64'd1);

    // Load formatting.
    push(1'b1, 5'd7, 32'hFFFF_FF80, 32'h0000_0103, 1'b0);
    do_load("lb", 5'd7, 32'h0000_0003, 3'b000, 3, 32'h80AA_BBCC, 1'b0);
    push(1'b1, 5'd7, 32'h0000_0080, 32'h0000_0103, 1'b0);
    do_load("lbu", 5'd7, 32'h0000_0003, 3'b100, 3, 32'h80AA_BBCC, 1'b0);
    push(1'b1, 5'd6, 32'hFFFF_8001, 32'h0000_0102, 1'b0);
    do_load("lh", 5'd6, 32'h0000_0002, 3'b001, 0, 32'h8001_0000, 1'b0);
    push(1'b1, 5'd6, 32'h0000_BBCC, 32'h0000_0100, 1'b0);
    do_load("lhu", 5'd6, 32'h0000_0000, 3'b101, 1, 32'h80AA_BBCC, 1'b0);
    push(1'b1, 5'd3, 32'h1122_3344, 32'h0000_0101, 1'b0);
    do_load("lw_f3_7", 5'd3, 32'h0000_0001, 3'b111, 2, 32'h1122_3344, 1'b0);

    // Bus error on the response.
    push(1'b0, 5'd4, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1);
    do_load("rerr", 5'd4, 32'h0000_0000, 3'b010, 2, 32'hDEAD_BEEF, 1'b0 | 1'b1);

    // Response in the last allowed LOAD_WAIT cycle still wins.
    push(1'b1, 5'd2, 32'hCAFE_F00D, 32'h0000_0100, 1'b0);
    do_load("limit_resp", 5'd2, 32'h0000_0000, 3'b010, 254, 32'hCAFE_F00D, 1'b0);

    // Timeout: no response for 255 LOAD_WAIT cycles.
    push(1'b0, 5'd9, 32'h0000_0040, 32'h0000_0140, 1'b1);
    issue(5'd9, 1'b1, 32'h0000_0040, 1'b1, 3'b010, 32'h0000_0140);
    expect_commit("timeout", 300, w);
    check("timeout_cycles", 64'(w), 64'd255);
    @(negedge clock);
    bus.lsu_rvalid = 1'b1; bus.lsu_rdata = 32'h5555_5555;
    check("stray_rready", {63'd0, bus.lsu_rready}, 64'd0);
    repeat (2) @(negedge clock);
    bus.lsu_rvalid = 1'b0;
    check("stray_no_commit", {63'd0, bus.commit_valid}, 64'd0);
    check("stray_ready", {63'd0, bus.exu_ready}, 64'd1);
    check("commit_count", 64'(commits_seen), 64'(commits_exp));
    check("instret_mid", bus.instret, instret_exp);

    // x0 destination: commit but no write, no hazard.
    push(1'b0, 5'd0, 32'h0000_0ABC, 32'h0000_0200, 1'b0);
    issue(5'd0, 1'b1, 32'h0000_0ABC, 1'b0, 3'b000, 32'h0000_0200);
    check("x0_wbu_rd", {59'd0, bus.wbu_rd}, 64'd0);
    expect_commit("x0", 1, w);
    @(negedge clock);

    // Reset while waiting on a load.
    issue(5'd9, 1'b1, 32'h0000_0000, 1'b1, 3'b010, 32'h0000_0300);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    instret_exp = 0;
    check("rstmid_ready", {63'd0, bus.exu_ready}, 64'd1);
    check("rstmid_wbu_rd", {59'd0, bus.wbu_rd}, 64'd0);
    check("rstmid_instret", bus.instret, 64'd0);
    check("rstmid_commit", {63'd0, bus.commit_valid}, 64'd0);
    bus.lsu_rvalid = 1'b1; bus.lsu_rdata = 32'h7777_7777;
    @(negedge clock);
    bus.lsu_rvalid = 1'b0;
    @(negedge clock);
    check("rstmid_late_resp", {63'd0, bus.commit_valid}, 64'd0);
    check("rstmid_count", 64'(commits_seen), 64'(commits_exp));

    push(1'b1, 5'd1, 32'h0000_0001, 32'h0000_0400, 1'b0);
    issue(5'd1, 1'b1, 32'h0000_0001, 1'b0, 3'b000, 32'h0000_0400);
    expect_commit("post_rst", 1, w);
    @(negedge clock);
    check("post_rst_instret", bus.instret, 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
